pcie_msi_irq_ctrl: RTL and testbench

Converts per-vector interrupt request pulses from the application core into single-cycle MSI requests on the UltraScale+ PCIe hard IP configuration interrupt interface. Sits between `fpga_core` interrupt sources and the `cfg_interrupt_msi_*` ports of the PCIe IP, all in the PCIe user clock domain.

It holds requests as pending bits and honours the host MSI enable, multiple-message-enable and mask settings. It arbitrates round-robin and retries on failure or timeout.

---
 rtl/pcie_msi_irq_ctrl_pkg.sv | 32 +++
 rtl/pcie_msi_irq_ctrl_if.sv | 49 ++++
 rtl/pcie_msi_irq_ctrl_rr_prio_select.sv | 35 +++
 rtl/pcie_msi_irq_ctrl.sv | 137 +++++++++++++
 tb/tb_pcie_msi_irq_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_msi_irq_ctrl_pkg.sv
// Shared definitions for the MSI interrupt controller: FSM encoding,
// vector-folding helper and the tie-off values for unused MSI IP inputs.
package pcie_msi_irq_ctrl_pkg;

  localparam int MSI_W    = 32;  // width of the MSI vector/mask words
  localparam int VEC_BITS = 5;   // log2(MSI_W)

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } msi_state_e;

  // Function 0 only, no pending-status, no TPH, default attributes.
  localparam logic [3:0]       MSI_SELECT       = 4'd0;
  localparam logic [MSI_W-1:0] MSI_PEND_STATUS  = '0;
  localparam logic             MSI_PS_DATA_EN   = 1'b0;
  localparam logic [3:0]       MSI_PS_FUNC_NUM  = 4'd0;
  localparam logic [2:0]       MSI_ATTR         = 3'd0;
  localparam logic             MSI_TPH_PRESENT  = 1'b0;
  localparam logic [1:0]       MSI_TPH_TYPE     = 2'd0;
  localparam logic [8:0]       MSI_TPH_ST_TAG   = 9'd0;
  localparam logic [3:0]       MSI_FUNC_NUM     = 4'd0;

  // Host grants 2^mme vectors (capped at 32); inputs fold onto vector i & (G-1).
  function automatic logic [VEC_BITS-1:0] fold_mask(input logic [2:0] mme);
    logic [2:0] l;
    l = (mme > 3'd5) ? 3'd5 : mme;
    return VEC_BITS'((6'd1 << l) - 6'd1);
  endfunction

endpackage

// File: rtl/pcie_msi_irq_ctrl_if.sv
// cfg_interrupt_msi_* bundle between the controller (master) and the
// PCIe hard IP (slave).
interface pcie_msi_irq_ctrl_if;
  import pcie_msi_irq_ctrl_pkg::*;

  logic [3:0]       cfg_interrupt_msi_enable;
  logic [11:0]      cfg_interrupt_msi_mmenable;
  logic             cfg_interrupt_msi_mask_update;
  logic [MSI_W-1:0] cfg_interrupt_msi_data;
  logic             cfg_interrupt_msi_sent;
  logic             cfg_interrupt_msi_fail;
  logic [MSI_W-1:0] cfg_interrupt_msi_int;
  logic [3:0]       cfg_interrupt_msi_select;
  logic [MSI_W-1:0] cfg_interrupt_msi_pending_status;
  logic             cfg_interrupt_msi_pending_status_data_enable;
  logic [3:0]       cfg_interrupt_msi_pending_status_function_num;
  logic [2:0]       cfg_interrupt_msi_attr;
  logic             cfg_interrupt_msi_tph_present;
  logic [1:0]       cfg_interrupt_msi_tph_type;
  logic [8:0]       cfg_interrupt_msi_tph_st_tag;
  logic [3:0]       cfg_interrupt_msi_function_number;

  modport master (
    input  cfg_interrupt_msi_enable, cfg_interrupt_msi_mmenable,
           cfg_interrupt_msi_mask_update, cfg_interrupt_msi_data,
           cfg_interrupt_msi_sent, cfg_interrupt_msi_fail,
    output cfg_interrupt_msi_int, cfg_interrupt_msi_select,
           cfg_interrupt_msi_pending_status,
           cfg_interrupt_msi_pending_status_data_enable,
           cfg_interrupt_msi_pending_status_function_num,
           cfg_interrupt_msi_attr, cfg_interrupt_msi_tph_present,
           cfg_interrupt_msi_tph_type, cfg_interrupt_msi_tph_st_tag,
           cfg_interrupt_msi_function_number
  );

  modport slave (
    output cfg_interrupt_msi_enable, cfg_interrupt_msi_mmenable,
           cfg_interrupt_msi_mask_update, cfg_interrupt_msi_data,
           cfg_interrupt_msi_sent, cfg_interrupt_msi_fail,
    input  cfg_interrupt_msi_int, cfg_interrupt_msi_select,
           cfg_interrupt_msi_pending_status,
           cfg_interrupt_msi_pending_status_data_enable,
           cfg_interrupt_msi_pending_status_function_num,
           cfg_interrupt_msi_attr, cfg_interrupt_msi_tph_present,
           cfg_interrupt_msi_tph_type, cfg_interrupt_msi_tph_st_tag,
           cfg_interrupt_msi_function_number
  );

endinterface

// File: rtl/pcie_msi_irq_ctrl_rr_prio_select.sv
// Combinational round-robin finder: first set request at or after the
// pointer, wrapping past N-1 back to 0.
module rr_prio_select #(
  parameter int N  = 32,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [N-1:0]  w_rot;
  logic [IW-1:0] w_off;
  logic [IW:0]   w_sum;

  // Rotate so the pointer position lands at bit 0; the doubled copy supplies the wrap.
  assign w_rot = N'({i_req, i_req} >> i_ptr);

  // Lowest set bit of the rotated vector = nearest request from the pointer.
  always_comb begin
    w_off   = '0;
    o_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off   = k[IW-1:0];
        o_valid = 1'b1;
      end
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);

endmodule

// File: rtl/pcie_msi_irq_ctrl.sv
// Per-input interrupt pulses -> single-cycle MSI requests to the PCIe hard
// IP. Holds pending bits, honours enable/MME/mask, round-robin arbitration,
// retries on fail or response timeout.
module pcie_msi_irq_ctrl
  import pcie_msi_irq_ctrl_pkg::*;
#(
  parameter int MSI_COUNT = 32,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MSI_COUNT-1:0] irq,
  pcie_msi_irq_ctrl_if.master  msi,
  output logic                 busy
);

  localparam int IW = (MSI_COUNT > 1) ? $clog2(MSI_COUNT) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  msi_state_e           r_state, w_state_nxt;
  logic [MSI_COUNT-1:0] r_pend, w_elig, w_clr;
  logic [MSI_W-1:0]     r_mask, r_int;
  logic [IW-1:0]        r_ptr, r_idx, w_sel_idx;
  logic                 w_sel_vld;
  logic [CW-1:0]        r_cnt;
  logic                 w_launch, w_ok, w_retry, w_cnt_last;
  logic [VEC_BITS-1:0]  w_fold, w_sel_vec;
  logic                 w_unused;

  assign w_fold = fold_mask(msi.cfg_interrupt_msi_mmenable[2:0]);

  // An input is eligible when pending and its folded vector is unmasked.
  for (genvar gi = 0; gi < MSI_COUNT; gi++) begin : g_elig
    assign w_elig[gi] = r_pend[gi] & ~r_mask[VEC_BITS'(gi) & w_fold];
  end

  rr_prio_select #(.N(MSI_COUNT), .IW(IW)) u_sel (
    .i_req   (w_elig),
    .i_ptr   (r_ptr),
    .o_idx   (w_sel_idx),
    .o_valid (w_sel_vld)
  );

  assign w_sel_vec  = VEC_BITS'(w_sel_idx) & w_fold;
  assign w_cnt_last = (r_cnt == CW'(TIMEOUT - 1));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state plus launch/complete strobes; fail wins over sent, sent wins over timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_ok        = 1'b0;
    w_retry     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (msi.cfg_interrupt_msi_enable[0] && w_sel_vld) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (msi.cfg_interrupt_msi_fail) begin
          w_retry     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (msi.cfg_interrupt_msi_sent) begin
          w_ok        = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_cnt_last) begin
          w_retry     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_clr = w_ok ? (MSI_COUNT'(1) << r_idx) : '0;

  // Pending bits: new requests OR in after the completion clear, so a coincident set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pend <= '0;
    else     r_pend <= (r_pend & ~w_clr) | irq;
  end

  // Host mask word, loaded on update pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_mask <= '0;
    else if (msi.cfg_interrupt_msi_mask_update) r_mask <= msi.cfg_interrupt_msi_data;
  end

  // Latch the winner at launch; the one-hot request is registered so it is high during ISSUE only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
      r_int <= '0;
    end else begin
      if (w_launch) r_idx <= w_sel_idx;
      r_int <= w_launch ? (MSI_W'(1) << w_sel_vec) : '0;
    end
  end

  // Round-robin pointer moves past the attempted input whether it succeeded or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_ptr <= '0;
    else if (w_ok | w_retry) r_ptr <= (r_idx == IW'(MSI_COUNT - 1)) ? '0 : r_idx + 1'b1;
  end

  // Response timeout counter: zeroed in ISSUE, counts each WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_cnt <= '0;
    else if (r_state == ST_ISSUE) r_cnt <= '0;
    else if (r_state == ST_WAIT)  r_cnt <= r_cnt + 1'b1;
  end

  assign busy = (r_state != ST_IDLE);

  assign msi.cfg_interrupt_msi_int                       = r_int;
  assign msi.cfg_interrupt_msi_select                    = MSI_SELECT;
  assign msi.cfg_interrupt_msi_pending_status            = MSI_PEND_STATUS;
  assign msi.cfg_interrupt_msi_pending_status_data_enable = MSI_PS_DATA_EN;
  assign msi.cfg_interrupt_msi_pending_status_function_num = MSI_PS_FUNC_NUM;
  assign msi.cfg_interrupt_msi_attr                      = MSI_ATTR;
  assign msi.cfg_interrupt_msi_tph_present               = MSI_TPH_PRESENT;
  assign msi.cfg_interrupt_msi_tph_type                  = MSI_TPH_TYPE;
  assign msi.cfg_interrupt_msi_tph_st_tag                = MSI_TPH_ST_TAG;
  assign msi.cfg_interrupt_msi_function_number           = MSI_FUNC_NUM;

  // Only function 0 is served.
  assign w_unused = ^{msi.cfg_interrupt_msi_enable[3:1], msi.cfg_interrupt_msi_mmenable[11:3]};

endmodule

// File: tb/tb_pcie_msi_irq_ctrl.sv
// Bench for pcie_msi_irq_ctrl: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level model.
module tb_pcie_msi_irq_ctrl;

  localparam int N   = 32;
  localparam int TMO = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] irq;
  logic         busy;
  int           checks = 0;
  int           errors = 0;
  bit           chk_en = 1'b0;
  int           n;

  always #5 clk = ~clk;

  pcie_msi_irq_ctrl_if u_if();

  pcie_msi_irq_ctrl #(.MSI_COUNT(N), .TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rst  (rst),
    .irq  (irq),
    .msi  (u_if),
    .busy (busy)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  // m_att: -1 no attempt; 0 = request cycle; k>=1 = k-th cycle awaiting response.
  bit [31:0] m_pend, m_mask;
  int        m_ptr = 0, m_att = -1, m_idx = 0, m_vec = 0;
  int        m_g, m_i;
  bit        m_done, m_ok;
  logic [31:0] m_exp_int;
  logic        m_exp_busy;

  assign m_exp_int  = (m_att == 0) ? (32'd1 << m_vec) : 32'd0;
  assign m_exp_busy = (m_att >= 0);

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 0; m_mask = 0; m_ptr = 0; m_att = -1; m_idx = 0; m_vec = 0;
    end else begin
      m_g    = 1 << ((u_if.cfg_interrupt_msi_mmenable[2:0] > 3'd5) ? 5 : int'(u_if.cfg_interrupt_msi_mmenable[2:0]));
      m_done = 0;
      m_ok   = 0;
      if (m_att < 0) begin
        if (u_if.cfg_interrupt_msi_enable[0]) begin
          for (int k = 0; k < N; k++) begin
            m_i = (m_ptr + k) % N;
            if (m_att < 0 && m_pend[m_i] && !m_mask[m_i % m_g]) begin
              m_att = 0; m_idx = m_i; m_vec = m_i % m_g;
            end
          end
        end
      end else if (m_att == 0) begin
        m_att = 1;
      end else begin
        if (u_if.cfg_interrupt_msi_fail)       m_done = 1;
        else if (u_if.cfg_interrupt_msi_sent) begin m_done = 1; m_ok = 1; end
        else if (m_att == TMO)                m_done = 1;
        else                                  m_att++;
      end
      if (m_ok)   m_pend[m_idx] = 1'b0;
      if (m_done) begin m_ptr = (m_idx + 1) % N; m_att = -1; end
      m_pend |= irq;
      if (u_if.cfg_interrupt_msi_mask_update) m_mask = u_if.cfg_interrupt_msi_data;
    end
  end

  // Per-cycle comparison of DUT against model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_int", u_if.cfg_interrupt_msi_int, m_exp_int);
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_exp_busy});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic [31:0] i, input logic s, input logic f);
    @(negedge clk); #1;
    irq = i[N-1:0];
    u_if.cfg_interrupt_msi_sent        = s;
    u_if.cfg_interrupt_msi_fail        = f;
    u_if.cfg_interrupt_msi_mask_update = 1'b0;
  endtask

  task automatic mask_load(input logic [31:0] d);
    @(negedge clk); #1;
    irq = '0;
    u_if.cfg_interrupt_msi_sent        = 1'b0;
    u_if.cfg_interrupt_msi_fail        = 1'b0;
    u_if.cfg_interrupt_msi_mask_update = 1'b1;
    u_if.cfg_interrupt_msi_data        = d;
  endtask

  task automatic wait_int(input string nm, input logic [31:0] e, input int budget, output int cnt);
    cnt = 0;
    do begin
      cyc(32'd0, 1'b0, 1'b0);
      cnt++;
    end while (u_if.cfg_interrupt_msi_int == 32'd0 && cnt < budget);
    if (u_if.cfg_interrupt_msi_int == 32'd0) begin
      checks++; errors++;
      $display("FAIL %s: got no request in %0d cycles want %h", nm, budget, e);
    end else begin
      chk(nm, u_if.cfg_interrupt_msi_int, e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    cyc(32'd0, 1'b0, 1'b0);
    cyc(32'd0, 1'b0, 1'b0);
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    irq = '0;
    u_if.cfg_interrupt_msi_enable      = 4'h1;
    u_if.cfg_interrupt_msi_mmenable    = 12'h5;
    u_if.cfg_interrupt_msi_mask_update = 1'b0;
    u_if.cfg_interrupt_msi_data        = '0;
    u_if.cfg_interrupt_msi_sent        = 1'b0;
    u_if.cfg_interrupt_msi_fail        = 1'b0;
    do_reset();
    chk_en = 1'b1;

    // Reset state and tie-offs
    cyc(32'd0, 1'b0, 1'b0);
    chk("rst_int", u_if.cfg_interrupt_msi_int, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("const_ps", u_if.cfg_interrupt_msi_pending_status, 32'd0);
    chk("const_misc", 32'({u_if.cfg_interrupt_msi_select,
                           u_if.cfg_interrupt_msi_pending_status_data_enable,
                           u_if.cfg_interrupt_msi_pending_status_function_num,
                           u_if.cfg_interrupt_msi_attr, u_if.cfg_interrupt_msi_tph_present,
                           u_if.cfg_interrupt_msi_tph_type, u_if.cfg_interrupt_msi_tph_st_tag,
                           u_if.cfg_interrupt_msi_function_number}), 32'd0);

    // irq[3] -> request exactly two cycles later, sent -> idle
    cyc(32'h8, 1'b0, 1'b0);
    cyc(32'd0, 1'b0, 1'b0);
    chk("t1_early", u_if.cfg_interrupt_msi_int, 32'd0);
    cyc(32'd0, 1'b0, 1'b0);
    chk("t1_int", u_if.cfg_interrupt_msi_int, 32'h8);
    chk("t1_model", m_exp_int, 32'h8);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    cyc(32'd0, 1'b1, 1'b0);
    cyc(32'd0, 1'b0, 1'b0);
    chk("t1_idle", {31'd0, busy}, 32'd0);
    repeat (4) cyc(32'd0, 1'b0, 1'b0);
    chk("t1_noreissue", {31'd0, busy}, 32'd0);

    // Round-robin: pointer 0 then pointer 5
    do_reset();
    cyc(32'h11, 1'b0, 1'b0);
    wait_int("t2_a", 32'h1, 10, n);
    cyc(32'd0, 1'b1, 1'b0);
    wait_int("t2_b", 32'h10, 10, n);
    chk("t2_b2b_gap", n, 2);
    cyc(32'd0, 1'b1, 1'b0);
    cyc(32'h11, 1'b0, 1'b0);
    wait_int("t2_c", 32'h1, 10, n);
    chk("t2_c_model", m_exp_int, 32'h1);
    cyc(32'd0, 1'b1, 1'b0);
    wait_int("t2_d", 32'h10, 10, n);
    cyc(32'd0, 1'b1, 1'b0);
    repeat (5) cyc(32'd0, 1'b0, 1'b0);
    chk("t2_norepeat", {31'd0, busy}, 32'd0);

    // Folding with G=4
    u_if.cfg_interrupt_msi_mmenable = 12'h2;
    cyc(32'h40, 1'b0, 1'b0);
    wait_int("t3_fold", 32'h4, 10, n);
    chk("t3_model", m_exp_int, 32'h4);
    cyc(32'd0, 1'b1, 1'b0);
    cyc(32'd0, 1'b0, 1'b0);
    u_if.cfg_interrupt_msi_mmenable = 12'h5;

    // Masked vector holds off until unmasked
    mask_load(32'h4);
    cyc(32'h4, 1'b0, 1'b0);
    repeat (6) cyc(32'd0, 1'b0, 1'b0);
    chk("t4_masked", {31'd0, busy}, 32'd0);
    mask_load(32'h0);
    cyc(32'd0, 1'b0, 1'b0);
    chk("t4_lat", u_if.cfg_interrupt_msi_int, 32'd0);
    cyc(32'd0, 1'b0, 1'b0);
    chk("t4_int", u_if.cfg_interrupt_msi_int, 32'h4);
    cyc(32'd0, 1'b1, 1'b0);
    cyc(32'd0, 1'b0, 1'b0);

    // Fail retry, then timeout retry
    cyc(32'h2, 1'b0, 1'b0);
    wait_int("t5_a", 32'h2, 10, n);
    cyc(32'd0, 1'b0, 1'b1);
    wait_int("t5_fail_retry", 32'h2, 10, n);
    chk("t5_fail_gap", n, 2);
    wait_int("t5_tmo_retry", 32'h2, 40, n);
    chk("t5_tmo_gap", n, TMO + 2);
    cyc(32'd0, 1'b1, 1'b0);
    cyc(32'd0, 1'b0, 1'b0);

    // Set and clear in the same cycle: set wins
    cyc(32'h8, 1'b0, 1'b0);
    wait_int("t6_a", 32'h8, 10, n);
    cyc(32'h8, 1'b1, 1'b0);
    wait_int("t6_again", 32'h8, 10, n);
    cyc(32'd0, 1'b1, 1'b0);
    repeat (4) cyc(32'd0, 1'b0, 1'b0);
    chk("t6_done", {31'd0, busy}, 32'd0);

    // Reset mid-WAIT, late sent ignored
    cyc(32'h1, 1'b0, 1'b0);
    wait_int("t7_a", 32'h1, 10, n);
    cyc(32'd0, 1'b0, 1'b0);
    @(negedge clk); #1;
    rst = 1'b1;
    cyc(32'd0, 1'b0, 1'b0);
    chk("t7_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    cyc(32'd0, 1'b1, 1'b0);
    repeat (5) cyc(32'd0, 1'b0, 1'b0);
    chk("t7_after", {31'd0, busy}, 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 2) begin
        mask_load($urandom & $urandom & $urandom);
      end else begin
        if ($urandom_range(0, 149) == 0)
          u_if.cfg_interrupt_msi_mmenable = 12'($urandom_range(0, 7));
        if (u_if.cfg_interrupt_msi_enable[0] ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 9) == 0))
          u_if.cfg_interrupt_msi_enable[0] = ~u_if.cfg_interrupt_msi_enable[0];
        cyc(($urandom_range(0, 5) == 0) ? ($urandom & $urandom & $urandom) : 32'd0,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      end
    end
    cyc(32'd0, 1'b0, 1'b0);
    cyc(32'd0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
